// File: rtl/alu_muldiv_seq.sv
// ============================================================================
// alu_muldiv_seq
// ----------------------------------------------------------------------------
// Multi-cycle unsigned MULTU / DIVU sequencer for the single-cycle core.
// The core has no array multiplier or divider, so this block borrows the
// shared 32-bit ALU for one add (multiply) or one subtract (divide) per clock.
// While it runs, it owns the ALU input mux and supplies its own operands and
// opcode. The HI/LO result is held until the next accepted start.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-high reset
//   start    in   operation request, only looked at while idle
//   op       in   0 = MULTU, 1 = DIVU
//   opa      in   multiplicand / dividend
//   opb      in   multiplier / divisor
//   busy     out  high while iterating
//   done     out  one-cycle pulse when hi/lo hold the final result
//   hi       out  product[63:32] or remainder
//   lo       out  product[31:0] or quotient
//   alu_own  out  core ALU mux selects this block's operands (equals busy)
//   alu_a    out  ALU operand a (zero when not iterating)
//   alu_b    out  ALU operand b (zero when not iterating)
//   alu_op   out  ALU opcode, ADD = 4'b0010, SUB = 4'b0110, zero when idle
//   alu_s    in   ALU result, combinational return in the same cycle
// ============================================================================
module alu_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             alu_own,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_s
);

    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic             r_opR;
    logic [4:0]       r_cnt;

    logic [WIDTH-1:0] w_sh;
    logic             w_carry;
    logic             w_borrow;
    logic             w_ge;

    // The partial remainder shifted left by one, pulling the next dividend
    // bit out of the top of lo. Its old MSB (r_hi[WIDTH-1]) falls off the
    // top and is folded back in through w_ge below.
    assign w_sh = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};

    // The ALU gives no carry-out, so the 33rd bit of hi + opnd is
    // reconstructed from the operand MSBs and the sum MSB.
    assign w_carry = (r_hi[WIDTH-1] & r_opnd[WIDTH-1]) |
                     ((r_hi[WIDTH-1] | r_opnd[WIDTH-1]) & ~alu_s[WIDTH-1]);

    // Likewise the borrow of sh - opnd is rebuilt from MSBs.
    assign w_borrow = (~w_sh[WIDTH-1] & r_opnd[WIDTH-1]) |
                      ((~w_sh[WIDTH-1] | r_opnd[WIDTH-1]) & alu_s[WIDTH-1]);

    // The true shifted remainder is 33 bits wide. If the bit that fell off
    // was set it is certainly >= opnd, and the 32-bit ALU difference is
    // still the correct new remainder.
    assign w_ge = r_hi[WIDTH-1] | ~w_borrow;

    assign hi = r_hi;
    assign lo = r_lo;

    // State register. Reset wins in every state, which is also how an
    // in-flight operation is aborted without ever producing done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and Moore outputs. Outside RUN the ALU lines are forced to
    // zero so the core's mux sees a quiet input when it is not selected.
    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        alu_own     = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_op      = 4'b0000;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                alu_own = 1'b1;
                alu_b   = r_opnd;
                if (r_opR) begin
                    alu_a  = w_sh;
                    alu_op = ALU_SUB;
                end else begin
                    alu_a  = r_hi;
                    alu_op = ALU_ADD;
                end
                if (r_cnt == LAST_ITER) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Datapath. An accepted start loads the operands; every RUN edge then
    // performs one shift-add (multiply) or one restoring-divide step. hi/lo
    // are left untouched in DONE and IDLE so the result stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
            r_opR  <= 1'b0;
            r_cnt  <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_opnd <= opb;
                        r_opR  <= op;
                        r_cnt  <= 5'd0;
                        r_hi   <= '0;
                        r_lo   <= opa;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_opR) begin
                        r_hi <= w_ge ? alu_s : w_sh;
                        r_lo <= {r_lo[WIDTH-2:0], w_ge};
                    end else if (r_lo[0]) begin
                        // {carry, sum, lo} shifted right by one position.
                        r_hi <= {w_carry, alu_s[WIDTH-1:1]};
                        r_lo <= {alu_s[0], r_lo[WIDTH-1:1]};
                    end else begin
                        r_hi <= {1'b0, r_hi[WIDTH-1:1]};
                        r_lo <= {r_hi[0], r_lo[WIDTH-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// ============================================================================
// tb_alu_muldiv_seq
// ----------------------------------------------------------------------------
// Bench for alu_muldiv_seq. A simple combinational ALU closes the loop on
// alu_a/alu_b/alu_op -> alu_s. A cycle-level reference model tracks how
// many cycles have passed since the last accepted start and computes the
// HI/LO result directly with 64-bit multiply, divide and modulo.
// ============================================================================
module tb_alu_muldiv_seq;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        alu_own;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_s;

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEn     = 0;

    // Reference model state: mdlPhase 0 = idle, 1..32 = iterating,
    // 33 = result cycle.
    int          mdlPhase = 0;
    logic [31:0] mdlHi    = 32'd0;
    logic [31:0] mdlLo    = 32'd0;
    logic [31:0] pendHi   = 32'd0;
    logic [31:0] pendLo   = 32'd0;
    logic [31:0] mdlOpnd  = 32'd0;
    logic        mdlOp    = 1'b0;

    alu_muldiv_seq #(.WIDTH(32), .ITER(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .opa     (opa),
        .opb     (opb),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .alu_own (alu_own),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .alu_s   (alu_s)
    );

    // Shared core ALU as the sequencer sees it.
    assign alu_s = (alu_op == ALU_ADD) ? (alu_a + alu_b) :
                   (alu_op == ALU_SUB) ? (alu_a - alu_b) : 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] refResult(input logic opSel,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] prod;
        if (!opSel) begin
            prod = {32'd0, a} * {32'd0, b};
            return prod;
        end
        if (b == 32'd0) begin
            return {a, 32'hFFFF_FFFF};
        end
        return {a % b, a / b};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference model, advanced on the same edge as the DUT.
    always @(posedge clk) begin
        if (rst) begin
            mdlPhase = 0;
            mdlHi    = 32'd0;
            mdlLo    = 32'd0;
        end else if (mdlPhase == 0) begin
            if (start) begin
                {pendHi, pendLo} = refResult(op, opa, opb);
                mdlOpnd  = opb;
                mdlOp    = op;
                mdlPhase = 1;
            end
        end else if (mdlPhase < 33) begin
            mdlPhase = mdlPhase + 1;
            if (mdlPhase == 33) begin
                mdlHi = pendHi;
                mdlLo = pendLo;
            end
        end else begin
            mdlPhase = 0;
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (checkEn) begin
            automatic logic expBusy = (mdlPhase >= 1) && (mdlPhase <= 32);
            checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
            checkOutput("done", {31'd0, done}, {31'd0, mdlPhase == 33});
            checkOutput("alu_own", {31'd0, alu_own}, {31'd0, expBusy});
            if (expBusy) begin
                checkOutput("alu_op run", {28'd0, alu_op},
                            {28'd0, mdlOp ? ALU_SUB : ALU_ADD});
                checkOutput("alu_b run", alu_b, mdlOpnd);
            end else begin
                checkOutput("alu_a quiet", alu_a, 32'd0);
                checkOutput("alu_b quiet", alu_b, 32'd0);
                checkOutput("alu_op quiet", {28'd0, alu_op}, 32'd0);
                checkOutput("hi", hi, mdlHi);
                checkOutput("lo", lo, mdlLo);
            end
        end
    end

    // Launch one operation and wait (bounded) for done. Optionally pokes
    // start with different operands in RUN and in DONE, both to be ignored.
    task automatic applyStimulus(input logic opIn, input logic [31:0] a,
                                 input logic [31:0] b, input bit pokeRun,
                                 input bit pokeDone, output int busyCycles,
                                 output int doneAt);
        @(negedge clk);
        start = 1'b1;
        op    = opIn;
        opa   = a;
        opb   = b;
        @(negedge clk);
        start = 1'b0;
        opa   = $urandom;
        opb   = $urandom;
        busyCycles = busy ? 1 : 0;
        doneAt     = -1;
        for (int c = 1; c <= 40 && doneAt < 0; c++) begin
            if (pokeRun && c == 5) begin
                start = 1'b1;
                op    = ~opIn;
                opa   = $urandom;
                opb   = $urandom;
            end
            if (pokeRun && c == 6) begin
                start = 1'b0;
            end
            @(negedge clk);
            if (busy) begin
                busyCycles++;
            end
            if (done) begin
                doneAt = c;
                if (pokeDone) begin
                    start = 1'b1;
                    op    = ~opIn;
                    opa   = $urandom;
                    opb   = $urandom;
                end
            end
        end
        if (doneAt < 0) begin
            checkOutput("done timeout", 32'd0, 32'd1);
        end
        if (pokeDone) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    // Launch, then check cycle counts and the literal result.
    task automatic runDirected(input string name, input logic opIn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expHi, input logic [31:0] expLo,
                               input bit pokeRun, input bit pokeDone);
        int busyCycles;
        int doneAt;
        applyStimulus(opIn, a, b, pokeRun, pokeDone, busyCycles, doneAt);
        checkOutput({name, " busy cycles"}, 32'(busyCycles), 32'd32);
        checkOutput({name, " done cycle"}, 32'(doneAt), 32'd32);
        checkOutput({name, " hi"}, hi, expHi);
        checkOutput({name, " lo"}, lo, expLo);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busyCycles;
        int doneAt;
        int donePulses;
        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        opa   = 32'd0;
        opb   = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset hi", hi, 32'd0);
        checkOutput("reset lo", lo, 32'd0);
        checkOutput("reset alu_own", {31'd0, alu_own}, 32'd0);
        checkOutput("reset alu_op", {28'd0, alu_op}, 32'd0);
        rst     = 1'b0;
        checkEn = 1'b1;

        runDirected("mul 3x5", 1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0);
        runDirected("mul max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        runDirected("div 100/7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
        runDirected("div max/1", 1'b1, 32'hFFFF_FFFF, 32'd1,
                    32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        runDirected("div by 0", 1'b1, 32'h1234_5678, 32'd0,
                    32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0);
        runDirected("ignored starts", 1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1, 1'b1);
        checkOutput("hold after ignored start hi", hi, 32'd0);
        checkOutput("hold after ignored start lo", lo, 32'd15);

        // Abort a multiply partway through with reset.
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        opa   = 32'hDEAD_BEEF;
        opb   = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort alu_own", {31'd0, alu_own}, 32'd0);
        checkOutput("abort hi", hi, 32'd0);
        checkOutput("abort lo", lo, 32'd0);
        donePulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) begin
                donePulses++;
            end
        end
        checkOutput("abort no done", 32'(donePulses), 32'd0);

        runDirected("mul 7x6", 1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1'b0);

        // Randomized back-to-back operations, checked by the model.
        for (int n = 0; n < 24; n++) begin
            logic        rOp;
            logic [31:0] rA;
            logic [31:0] rB;
            rOp = 1'($urandom_range(0, 1));
            rA  = $urandom;
            case ($urandom_range(0, 3))
                0:       rB = 32'd0;
                1:       rB = 32'($urandom_range(1, 255));
                default: rB = $urandom;
            endcase
            applyStimulus(rOp, rA, rB, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), busyCycles, doneAt);
            checkOutput("random busy cycles", 32'(busyCycles), 32'd32);
            checkOutput("random done cycle", 32'(doneAt), 32'd32);
        end

        repeat (3) @(negedge clk);
        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
